apb_req_master: RTL
===================

// Module: apb_req_master
// PURPOSE
//  APB requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers toward apb_slave.
//  Returns one response per command. Holds a 1-entry lookahead so back-to-back transfers assert trnsfr.
//  Abort timer terminates hung ACCESS phases. Sits between a local command source and the APB bus.
// PARAMETERS
//  ADDR_WIDTH  32  width of cmd_addr / addr
//  DATA_WIDTH  32  width of wdata/rdata; strobe width = DATA_WIDTH/8 (DATA_WIDTH multiple of 8)
//  TIMEOUT     16  max ACCESS wait cycles with ready=0 before abort; 0 = never abort
// PORTS
//  clk          in   1             clock, all logic on rising edge
//  rst_n        in   1             reset, asynchronous, active-low
//  cmd_valid    in   1             command offered
//  cmd_ready    out  1             command accepted when cmd_valid&cmd_ready at clk edge
//  cmd_write    in   1             1=write, 0=read
//  cmd_addr     in   ADDR_WIDTH    transfer address
//  cmd_wdata    in   DATA_WIDTH    write data
//  cmd_strobe   in   DATA_WIDTH/8  byte enables
//  rsp_valid    out  1             1-cycle response pulse
//  rsp_rdata    out  DATA_WIDTH    read data (0 for writes/aborts)
//  rsp_slverr   out  1             slave error or timeout
//  rsp_timeout  out  1             transfer aborted by timer
//  busy         out  1             state!=IDLE or lookahead occupied
//  sel,enable   out  1,1           APB PSEL/PENABLE
//  write        out  1             APB PWRITE
//  addr         out  ADDR_WIDTH    APB PADDR
//  wdata        out  DATA_WIDTH    APB PWDATA
//  strobe       out  DATA_WIDTH/8  APB PSTRB
//  trnsfr       out  1             another transfer follows this ACCESS
//  ready        in   1             APB PREADY
//  rdata        in   DATA_WIDTH    APB PRDATA
//  slverr       in   1             APB PSLVERR
// BEHAVIOUR
//  Reset: every output 0; state IDLE; cur/nxt slots empty; wait counter 0. Reset mid-transfer drops sel/enable
//   immediately (async), discards both slots, emits no response.
//  Storage: cur (transfer on bus), nxt (lookahead). cmd_ready = ~nxt_valid (combinational).
//  Accept: goes to cur if cur empty or cur completes this cycle with nxt empty; else into nxt.
//  FSM (states IDLE, SETUP, ACCESS):
//   IDLE:   sel=0,enable=0, addr/write/wdata/strobe=0. Accept -> SETUP next cycle.
//   SETUP:  sel=1,enable=0, bus fields = cur. Always -> ACCESS after exactly 1 cycle.
//   ACCESS: sel=1,enable=1, bus fields held from SETUP. Wait counter +1 per cycle with ready=0.
//    ready=1 -> complete; timeout (counter==TIMEOUT, TIMEOUT!=0, ready=0) -> abort.
//    On complete/abort: next state SETUP if nxt_valid or a command is accepted this cycle, else IDLE;
//    nxt moves to cur; counter clears.
//  trnsfr = (state==ACCESS) & (nxt_valid | cmd_valid); 0 in IDLE/SETUP.
//  Response (registered, cycle after completing edge): rsp_valid=1 for 1 cycle.
//   complete read: rsp_rdata=rdata, rsp_slverr=slverr; complete write: rsp_rdata=0, rsp_slverr=slverr.
//   abort: rsp_rdata=0, rsp_slverr=1, rsp_timeout=1. rsp_* are 0 whenever rsp_valid=0.
//  Latency: accept edge T -> SETUP T+1 -> ACCESS T+2 -> zero-wait rsp_valid at T+3.
//  Back-to-back: no IDLE cycle between transfers; new SETUP follows completing ACCESS directly.
//  Ordering: responses in command order, exactly one per accepted command.
//  Counter width $clog2(TIMEOUT+1); saturates, never wraps.
//  ready/slverr/rdata are ignored outside ACCESS.
// TESTING
//  1 Write addr=0x10,wdata=0xA5A5_0001,strobe=0xF, ready=1 in ACCESS -> SETUP/ACCESS 1 cycle each;
//    rsp_valid at T+3, rsp_slverr=0, rsp_rdata=0.
//  2 Read addr=0x20, ready low 2 ACCESS cycles, then rdata=0xDEAD_BEEF ->
//    3 ACCESS cycles, bus fields stable, rsp_rdata=0xDEAD_BEEF.
//  3 Three writes presented consecutively with cmd_valid held -> trnsfr=1 in first two ACCESS, 0 in third;
//    no IDLE between; cmd_ready drops when nxt full; 3 in-order responses.
//  4 Read with slverr=1 at ready=1 -> rsp_slverr=1, rsp_timeout=0, rsp_rdata=rdata sampled.
//  5 TIMEOUT=4, ready tied 0 -> abort after 4 wait cycles, rsp_slverr=1, rsp_timeout=1, next cycle IDLE.
//  6 rst_n low during ACCESS with nxt full -> sel/enable 0 asynchronously, no rsp_valid, busy=0,
//    cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_req_master.sv
// APB requester: converts a valid/ready command stream into APB SETUP/ACCESS transfers,
// with a one-entry lookahead for back-to-back transfers and an ACCESS abort timer.
module apb_req_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strobe,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      sel,
    output logic                      enable,
    output logic                      write,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   strobe,
    output logic                      trnsfr,
    input  logic                      ready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic                      slverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state;
    state_t state_next;

    logic                  cur_write;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [STRB_WIDTH-1:0] cur_strobe;

    logic                  nxt_valid;
    logic                  nxt_write;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [DATA_WIDTH-1:0] nxt_wdata;
    logic [STRB_WIDTH-1:0] nxt_strobe;

    logic [CNT_WIDTH-1:0]  wait_cnt;

    logic in_access;
    logic accept;
    logic abort;
    logic done;
    logic load_cur;
    logic load_nxt;

    // cmd_ready is gated by reset so every output reads 0 while reset is held
    assign cmd_ready = rst_n & ~nxt_valid;

    always_comb begin
        in_access = (state == ACCESS);
        accept    = cmd_valid & cmd_ready;
        abort     = TIMEOUT_EN & in_access & ~ready & (wait_cnt == CNT_LIMIT);
        done      = in_access & (ready | abort);
        // cur is empty exactly when IDLE; it frees up on completion if no lookahead waits
        load_cur  = accept & ((state == IDLE) | (done & ~nxt_valid));
        load_nxt  = accept & ~load_cur;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (done) state_next = (nxt_valid | accept) ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel    = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
        addr   = '0;
        wdata  = '0;
        strobe = '0;
        trnsfr = 1'b0;
        busy   = (state != IDLE) | nxt_valid;
        if (state != IDLE) begin
            sel    = 1'b1;
            enable = in_access;
            write  = cur_write;
            addr   = cur_addr;
            wdata  = cur_wdata;
            strobe = cur_strobe;
            trnsfr = in_access & (nxt_valid | cmd_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_write  <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            cur_strobe <= '0;
            nxt_valid  <= 1'b0;
            nxt_write  <= 1'b0;
            nxt_addr   <= '0;
            nxt_wdata  <= '0;
            nxt_strobe <= '0;
        end else begin
            if (load_cur) begin
                cur_write  <= cmd_write;
                cur_addr   <= cmd_addr;
                cur_wdata  <= cmd_wdata;
                cur_strobe <= cmd_strobe;
            end else if (done && nxt_valid) begin
                cur_write  <= nxt_write;
                cur_addr   <= nxt_addr;
                cur_wdata  <= nxt_wdata;
                cur_strobe <= nxt_strobe;
            end
            if (load_nxt) begin
                nxt_valid  <= 1'b1;
                nxt_write  <= cmd_write;
                nxt_addr   <= cmd_addr;
                nxt_wdata  <= cmd_wdata;
                nxt_strobe <= cmd_strobe;
            end else if (done) begin
                nxt_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!in_access || done) begin
            wait_cnt <= '0;
        end else if (!ready && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= done;
            rsp_rdata   <= (done && ready && !cur_write) ? rdata : '0;
            rsp_slverr  <= abort | (done & ready & slverr);
            rsp_timeout <= abort;
        end
    end

endmodule
